// File: rtl/serial_tx_param.sv
// Parametrised framed serial transmitter with a one-entry holding buffer and valid/ready intake.
// Optional even-parity bit between data and stop bits is enabled by defining TX_PARITY_EN.
module serial_tx_param #(
  parameter int DATA_W       = 55,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              Clk_S,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] TX_Data,
  input  logic              TX_Data_Valid,
  output logic              TX_Ready,
  output logic              S_Data,
  output logic              TX_Busy,
  output logic              TX_Done
);

  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(STOP_LEN + 1);
  localparam int BIT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  if (STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 1 || DATA_W < 2) begin : g_param_check
    $error("serial_tx_param: illegal parameter set");
  end

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              state_q;
  logic [DATA_W-1:0]   hold_q;
  logic                hold_full_q;
  logic                ready_en_q;
  logic [DATA_W-1:0]   shift_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic                s_data_q;
  logic                busy_q;
  logic                done_q;
`ifdef TX_PARITY_EN
  logic                par_q;
`endif

  logic                accept_s;
  logic                first_bit_s;
  logic                next_bit_s;
  logic [DATA_W-1:0]   shift_d;
  logic [CNT_W-1:0]    cnt_d;

  assign accept_s    = TX_Data_Valid & TX_Ready;
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign first_bit_s = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];
  assign next_bit_s  = (MSB_FIRST != 0) ? shift_q[DATA_W-2] : shift_q[1];
  assign shift_d     = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};

  assign TX_Ready = ready_en_q & ~hold_full_q;
  assign S_Data   = s_data_q;
  assign TX_Busy  = busy_q;
  assign TX_Done  = done_q;

  // Frame FSM; serial outputs are registered for the cycle being entered.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_en_q  <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      s_data_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      ready_en_q <= 1'b1;
      done_q     <= 1'b0;
      if (accept_s) begin
        hold_q      <= TX_Data;
        hold_full_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (hold_full_q) begin
            state_q     <= S_START;
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            s_data_q    <= 1'b0;
            busy_q      <= 1'b1;
`ifdef TX_PARITY_EN
            par_q       <= ^hold_q;
`endif
          end
        end
        S_START: begin
          if (cnt_q == BIT_LAST) begin
            state_q   <= S_DATA;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            s_data_q  <= first_bit_s;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (bit_cnt_q == DATA_LAST) begin
`ifdef TX_PARITY_EN
              state_q  <= S_PARITY;
              s_data_q <= par_q;
`else
              state_q  <= S_STOP;
              s_data_q <= 1'b1;
              done_q   <= (STOP_LEN == 1);
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              shift_q   <= shift_d;
              s_data_q  <= next_bit_s;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
`ifdef TX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            state_q  <= S_STOP;
            cnt_q    <= '0;
            s_data_q <= 1'b1;
            done_q   <= (STOP_LEN == 1);
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == STOP_LAST) begin
            // A buffered word starts its frame immediately, with no idle gap.
            if (hold_full_q) begin
              state_q     <= S_START;
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              cnt_q       <= '0;
              s_data_q    <= 1'b0;
              busy_q      <= 1'b1;
`ifdef TX_PARITY_EN
              par_q       <= ^hold_q;
`endif
            end else begin
              state_q  <= S_IDLE;
              cnt_q    <= '0;
              s_data_q <= 1'b1;
              busy_q   <= 1'b0;
            end
          end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == STOP_LAST);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          s_data_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_param.sv
// Scoreboard bench for serial_tx_param: four configurations share one clock and reset.
module tb_serial_tx_param;

`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  d8 [3];
  logic        v8 [3];
  logic        r8 [3];
  logic        sd8 [3];
  logic        b8 [3];
  logic        dn8 [3];
  logic [54:0] d55;
  logic        v55, r55, sd55, b55, dn55;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  serial_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .MSB_FIRST(1), .STOP_BITS(1)) u_msb (
    .Clk_S(clk), .Rst_n(rst_n), .TX_Data(d8[0]), .TX_Data_Valid(v8[0]), .TX_Ready(r8[0]),
    .S_Data(sd8[0]), .TX_Busy(b8[0]), .TX_Done(dn8[0]));
  serial_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .MSB_FIRST(0), .STOP_BITS(1)) u_lsb (
    .Clk_S(clk), .Rst_n(rst_n), .TX_Data(d8[1]), .TX_Data_Valid(v8[1]), .TX_Ready(r8[1]),
    .S_Data(sd8[1]), .TX_Busy(b8[1]), .TX_Done(dn8[1]));
  serial_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .MSB_FIRST(1), .STOP_BITS(2)) u_b2b (
    .Clk_S(clk), .Rst_n(rst_n), .TX_Data(d8[2]), .TX_Data_Valid(v8[2]), .TX_Ready(r8[2]),
    .S_Data(sd8[2]), .TX_Busy(b8[2]), .TX_Done(dn8[2]));
  serial_tx_param u_def (
    .Clk_S(clk), .Rst_n(rst_n), .TX_Data(d55), .TX_Data_Valid(v55), .TX_Ready(r55),
    .S_Data(sd55), .TX_Busy(b55), .TX_Done(dn55));

  // {ready, s_data, busy, done} of instance i
  function automatic logic [3:0] obs(input int i);
    case (i)
      0: return {r8[0], sd8[0], b8[0], dn8[0]};
      1: return {r8[1], sd8[1], b8[1], dn8[1]};
      2: return {r8[2], sd8[2], b8[2], dn8[2]};
      3: return {r55, sd55, b55, dn55};
      default: return 4'b0000;
    endcase
  endfunction

  task automatic drive(input int i, input logic v, input logic [54:0] d);
    if (i == 3) begin
      v55 = v; d55 = d;
    end else begin
      v8[i] = v; d8[i] = d[7:0];
    end
  endtask

  // Reference model: expected S_Data level for every cycle of one frame
  task automatic push_frame(input logic [54:0] d, input int w, input int cpb, input bit msb, input int stops);
    logic p, b;
    p = 1'b0;
    repeat (cpb) exp_q.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      b = d[msb ? w - 1 - i : i];
      p ^= b;
      repeat (cpb) exp_q.push_back(b);
    end
    if (PAR == 1) repeat (cpb) exp_q.push_back(p);
    repeat (stops * cpb) exp_q.push_back(1'b1);
  endtask

  task automatic test_reset;
    logic [3:0] o;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 55'd0);
    #22 rst_n = 1'b1;
    #1 o = obs(3);
    n_chk++; if (o !== 4'b0100) begin n_fail++; $display("FAIL reset_state got %b exp 0100", o); end
    @(posedge clk); #1 o = obs(3);
    n_chk++; if (o[3] !== 1'b1) begin n_fail++; $display("FAIL ready_after_release got %b exp 1", o[3]); end
    @(posedge clk); #3 rst_n = 1'b0;
    #1 o = obs(3);
    n_chk++; if (o !== 4'b0100) begin n_fail++; $display("FAIL async_reset got %b exp 0100", o); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 o = obs(0);
    n_chk++; if (o !== 4'b1100) begin n_fail++; $display("FAIL ready_after_rerelease got %b exp 1100", o); end
  endtask

  task automatic test_single_frame(input int inst, input logic [7:0] w, input bit msb);
    logic [3:0] o;
    logic       e;
    int         fl;
    exp_q.delete();
    push_frame({47'd0, w}, 8, 4, msb, 1);
    fl = exp_q.size();
    @(posedge clk); #1 drive(inst, 1'b1, {47'd0, w});
    @(posedge clk); #1 drive(inst, 1'b0, 55'd0);
    o = obs(inst);
    n_chk++; if (o !== 4'b0100) begin n_fail++; $display("FAIL accept_state w=%h got %b exp 0100", w, o); end
    for (int j = 1; j <= fl + 1; j++) begin
      @(posedge clk); @(negedge clk);
      o = obs(inst);
      e = (j <= fl) ? exp_q.pop_front() : 1'b1;
      n_chk++; if (o[2] !== e) begin n_fail++; $display("FAIL sdata w=%h j=%0d got %b exp %b", w, j, o[2], e); end
      n_chk++; if (o[1] !== (j <= fl)) begin n_fail++; $display("FAIL busy w=%h j=%0d got %b exp %b", w, j, o[1], (j <= fl)); end
      n_chk++; if (o[0] !== (j == fl)) begin n_fail++; $display("FAIL done w=%h j=%0d got %b exp %b", w, j, o[0], (j == fl)); end
      if (j == 1) begin
        n_chk++; if (o[3] !== 1'b1) begin n_fail++; $display("FAIL ready_return got %b exp 1", o[3]); end
      end
    end
  endtask

  task automatic test_lsb_first;
    test_single_frame(1, 8'hA5, 1'b0);
    test_single_frame(1, 8'h01, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [3:0] o;
    logic       e, er;
    int         fl1, tot;
    exp_q.delete();
    push_frame(55'h0A5, 8, 4, 1'b1, 2);
    fl1 = exp_q.size();
    push_frame(55'h03C, 8, 4, 1'b1, 2);
    tot = exp_q.size();
    @(posedge clk); #1 drive(2, 1'b1, 55'h0A5);
    @(posedge clk); #1 drive(2, 1'b1, 55'h03C);
    for (int j = 1; j <= tot + 1; j++) begin
      @(posedge clk); #1
      if (j == 2) drive(2, 1'b0, 55'd0);
      @(negedge clk);
      o  = obs(2);
      e  = (j <= tot) ? exp_q.pop_front() : 1'b1;
      er = (j == 1) || (j > fl1);
      n_chk++; if (o[2] !== e) begin n_fail++; $display("FAIL b2b_sdata j=%0d got %b exp %b", j, o[2], e); end
      n_chk++; if (o[1] !== (j <= tot)) begin n_fail++; $display("FAIL b2b_busy j=%0d got %b exp %b", j, o[1], (j <= tot)); end
      n_chk++; if (o[0] !== (j == fl1 || j == tot)) begin n_fail++; $display("FAIL b2b_done j=%0d got %b", j, o[0]); end
      n_chk++; if (o[3] !== er) begin n_fail++; $display("FAIL b2b_ready j=%0d got %b exp %b", j, o[3], er); end
    end
  endtask

  task automatic test_default_width;
    logic [3:0]  o;
    logic        e;
    logic [54:0] w;
    int          fl, dones;
    w = {3'b111, 52'd0};
    dones = 0;
    exp_q.delete();
    push_frame(w, 55, 1, 1'b1, 1);
    fl = exp_q.size();
    @(posedge clk); #1 drive(3, 1'b1, w);
    @(posedge clk); #1 drive(3, 1'b0, 55'd0);
    for (int j = 1; j <= fl + 3; j++) begin
      @(posedge clk); @(negedge clk);
      o = obs(3);
      e = (j <= fl) ? exp_q.pop_front() : 1'b1;
      if (o[0] === 1'b1) dones++;
      n_chk++; if (o[2] !== e) begin n_fail++; $display("FAIL wide_sdata j=%0d got %b exp %b", j, o[2], e); end
      n_chk++; if (o[1] !== (j <= fl)) begin n_fail++; $display("FAIL wide_busy j=%0d got %b exp %b", j, o[1], (j <= fl)); end
    end
    n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL wide_done_count got %0d exp 1", dones); end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] o;
    logic [7:0] a5;
    a5 = 8'hA5;
    @(posedge clk); #1 drive(0, 1'b1, 55'h0A5);
    @(posedge clk); #1 drive(0, 1'b1, 55'h03C);
    @(posedge clk);
    @(posedge clk); #1 drive(0, 1'b0, 55'd0);
    o = obs(0);
    n_chk++; if (o[3] !== 1'b0) begin n_fail++; $display("FAIL mid_buffered_ready got %b exp 0", o[3]); end
    repeat (16) @(posedge clk);
    #2 o = obs(0);
    n_chk++; if (o[2:1] !== {a5[4], 1'b1}) begin n_fail++; $display("FAIL mid_bit3 got %b exp %b", o[2:1], {a5[4], 1'b1}); end
    rst_n = 1'b0;
    #1 o = obs(0);
    n_chk++; if (o !== 4'b0100) begin n_fail++; $display("FAIL mid_async_reset got %b exp 0100", o); end
    @(negedge clk) rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); @(negedge clk);
      o = obs(0);
      n_chk++; if (o !== 4'b1100) begin n_fail++; $display("FAIL mid_discard j=%0d got %b exp 1100", j, o); end
    end
    test_single_frame(0, 8'h3C, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame(0, 8'hA5, 1'b1);
    test_single_frame(0, 8'h07, 1'b1);
    test_lsb_first();
    test_back_to_back();
    test_default_width();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
